// File: rtl/ps2_kbd_ctrl_if.sv
// Key-event interface between the PS/2 byte receiver, the decoder and the application logic.
// The slave modport belongs to the decoder; the master modport belongs to the driving side.
interface ps2_kbd_ctrl_if;
   logic       rx_done_tick;
   logic [7:0] dato;
   logic       rd_en;
   logic       ev_valid;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_break;
   logic       fifo_full;
   logic       overflow;
   logic       timeout_tick;

   modport slave (
      input  rx_done_tick, dato, rd_en,
      output ev_valid, ev_code, ev_ext, ev_break, fifo_full, overflow, timeout_tick
   );

   modport master (
      output rx_done_tick, dato, rd_en,
      input  ev_valid, ev_code, ev_ext, ev_break, fifo_full, overflow, timeout_tick
   );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 set-2 sequencer: folds E0/F0 prefixes into key events, buffers them in a
// show-ahead FIFO, and uses a watchdog to abandon stalled prefix sequences.
module ps2_kbd_ctrl #(
   parameter int unsigned DEPTH_LOG2  = 2,
   parameter int unsigned TIMEOUT_CYC = 200000,
   parameter int unsigned CNT_W       = 18
) (
   input  logic          clk_nexys,
   input  logic          reset,
   ps2_kbd_ctrl_if.slave bus
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   typedef logic [DEPTH_LOG2-1:0] ptr_t;
   typedef logic [DEPTH_LOG2:0]   cnt_t;
   typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_e;

   localparam cnt_t             FULL_CNT = cnt_t'(DEPTH);
   localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYC - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wdog_q, wdog_d;
   logic             tout_q, tout_d;
   logic             wd_expire;
   logic             is_e0, is_f0, is_status;
   logic             push_req;
   logic [9:0]       push_data;

   logic [9:0]       mem_q [DEPTH];
   ptr_t             wr_ptr_q, rd_ptr_q;
   cnt_t             count_q, count_d;
   logic             valid_q, full_q, ovf_q;
   logic [9:0]       last_q;
   logic [9:0]       head;
   logic             pop_ok, push_ok;

   assign is_e0     = (bus.dato == 8'hE0);
   assign is_f0     = (bus.dato == 8'hF0);
   assign is_status = (bus.dato == 8'hAA) || (bus.dato == 8'hFA) || (bus.dato == 8'hFC) ||
                      (bus.dato == 8'hEE) || (bus.dato == 8'h00) || (bus.dato == 8'hFF);

   always_ff @(posedge clk_nexys or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         wdog_q  <= '0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wdog_q  <= wdog_d;
         tout_q  <= tout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.rx_done_tick) begin
         unique case (state_q)
            IDLE:     if (is_e0) state_d = GOT_E0; else if (is_f0) state_d = GOT_F0;
            GOT_E0:   if (is_f0) state_d = GOT_E0F0; else if (!is_e0) state_d = IDLE;
            GOT_F0:   if (is_e0) state_d = GOT_E0F0; else if (!is_f0) state_d = IDLE;
            GOT_E0F0: if (!(is_e0 || is_f0)) state_d = IDLE;
            default:  state_d = IDLE;
         endcase
      end else if (wd_expire) begin
         state_d = IDLE;
      end
   end

   always_comb begin
      wd_expire = (state_q != IDLE) && !bus.rx_done_tick && (wdog_q == WD_LAST);
      tout_d    = wd_expire;
      wdog_d    = (bus.rx_done_tick || state_q == IDLE) ? '0 : wdog_q + CNT_W'(1);
      push_req  = 1'b0;
      push_data = {2'b00, bus.dato};
      if (bus.rx_done_tick && !is_e0 && !is_f0) begin
         unique case (state_q)
            IDLE:     push_req = !is_status;
            GOT_E0:   begin push_req = 1'b1; push_data = {2'b10, bus.dato}; end
            GOT_F0:   begin push_req = 1'b1; push_data = {2'b01, bus.dato}; end
            GOT_E0F0: begin push_req = 1'b1; push_data = {2'b11, bus.dato}; end
            default:  push_req = 1'b0;
         endcase
      end
   end

   // A pop frees the slot in the same cycle, so a push into a full FIFO is not dropped.
   always_comb begin
      pop_ok  = bus.rd_en && (count_q != '0);
      push_ok = push_req && ((count_q != FULL_CNT) || pop_ok);
      count_d = count_q;
      if (push_ok && !pop_ok)      count_d = count_q + cnt_t'(1);
      else if (!push_ok && pop_ok) count_d = count_q - cnt_t'(1);
   end

   always_ff @(posedge clk_nexys) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

   always_ff @(posedge clk_nexys or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
         last_q   <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            last_q   <= mem_q[rd_ptr_q];
         end
         if (push_req && !push_ok) ovf_q <= 1'b1;
         count_q <= count_d;
         valid_q <= (count_d != '0);
         full_q  <= (count_d == FULL_CNT);
      end
   end

   // While empty the outputs keep showing the most recently popped event.
   assign head = valid_q ? mem_q[rd_ptr_q] : last_q;

   assign bus.ev_valid     = valid_q;
   assign bus.ev_code      = head[7:0];
   assign bus.ev_ext       = head[9];
   assign bus.ev_break     = head[8];
   assign bus.fifo_full    = full_q;
   assign bus.overflow     = ovf_q;
   assign bus.timeout_tick = tout_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: a queue-based event model checked every cycle,
// plus literal expectations for the listed scenarios.
module tb_ps2_kbd_ctrl;
   localparam int unsigned TO    = 50;
   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   ps2_kbd_ctrl_if bus();

   ps2_kbd_ctrl #(.DEPTH_LOG2(2), .TIMEOUT_CYC(TO), .CNT_W(6)) dut (
      .clk_nexys (clk),
      .reset     (reset),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   // Model: pending prefix flags, an event queue, and cycle stamps for the watchdog.
   logic [9:0] mq[$];
   logic [9:0] m_last;
   bit         m_ovf, m_tout, m_ext, m_brk, m_pend;
   int         m_cyc, m_last_rx;

   function automatic bit status_byte(input logic [7:0] b);
      return b == 8'hAA || b == 8'hFA || b == 8'hFC || b == 8'hEE || b == 8'h00 || b == 8'hFF;
   endfunction

   always @(posedge clk or posedge reset) begin
      bit         pop, have;
      logic [9:0] ev;
      if (reset) begin
         mq.delete();
         m_last = '0; m_ovf = 0; m_tout = 0; m_ext = 0; m_brk = 0; m_pend = 0;
         m_cyc = 0; m_last_rx = 0;
      end else begin
         m_cyc++;
         m_tout = 0;
         have = 0;
         ev = '0;
         pop = bus.rd_en && mq.size() > 0;
         if (bus.rx_done_tick) begin
            m_last_rx = m_cyc;
            if (bus.dato == 8'hE0) begin m_ext = 1; m_pend = 1; end
            else if (bus.dato == 8'hF0) begin m_brk = 1; m_pend = 1; end
            else if (!m_pend && status_byte(bus.dato)) ;
            else begin
               ev = {m_ext, m_brk, bus.dato}; have = 1;
               m_ext = 0; m_brk = 0; m_pend = 0;
            end
         end else if (m_pend && (m_cyc - m_last_rx) == TO) begin
            m_ext = 0; m_brk = 0; m_pend = 0; m_tout = 1;
         end
         if (pop) m_last = mq.pop_front();
         if (have) begin
            if (mq.size() < DEPTH) mq.push_back(ev);
            else m_ovf = 1;
         end
      end
   end

   always @(negedge clk) begin
      logic [9:0]  h;
      logic [14:0] exp_v, act_v;
      h = (mq.size() > 0) ? mq[0] : m_last;
      exp_v = {(mq.size() > 0), h[7:0], h[9], h[8], (mq.size() == DEPTH), m_ovf, m_tout};
      act_v = {bus.ev_valid, bus.ev_code, bus.ev_ext, bus.ev_break, bus.fifo_full,
               bus.overflow, bus.timeout_tick};
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL model t=%0t got=%h want=%h (valid,code,ext,brk,full,ovf,tout)",
                  $time, act_v, exp_v);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bus.rx_done_tick = 1'b1; bus.dato = b;
      cyc(1);
      bus.rx_done_tick = 1'b0;
   endtask

   task automatic send_pop(input logic [7:0] b);
      bus.rx_done_tick = 1'b1; bus.dato = b; bus.rd_en = 1'b1;
      cyc(1);
      bus.rx_done_tick = 1'b0; bus.rd_en = 1'b0;
   endtask

   task automatic pop();
      bus.rd_en = 1'b1;
      cyc(1);
      bus.rd_en = 1'b0;
   endtask

   task automatic head_is(input string name, input logic [7:0] c, input logic e, input logic b);
      chk({name, "_valid"}, 32'(bus.ev_valid), 32'd1);
      chk({name, "_ev"}, {22'd0, bus.ev_ext, bus.ev_break, bus.ev_code}, {22'd0, e, b, c});
   endtask

   task automatic outputs_zero(input string name);
      chk(name, {19'd0, bus.ev_valid, bus.ev_code, bus.ev_ext, bus.ev_break, bus.fifo_full,
                 bus.overflow, bus.timeout_tick}, 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      outputs_zero("reset_outputs");
      cyc(1);
      reset = 1'b0;
   endtask

   initial begin
      int first, highs;
      logic [7:0] codes [5];
      codes[0] = 8'h16; codes[1] = 8'h1E; codes[2] = 8'h26; codes[3] = 8'h25; codes[4] = 8'h2E;
      bus.rx_done_tick = 1'b0; bus.dato = '0; bus.rd_en = 1'b0;
      cyc(2);
      do_reset();

      // make then break of 0x1C
      chk("idle_valid", 32'(bus.ev_valid), 32'd0);
      send(8'h1C);
      head_is("make1C", 8'h1C, 1'b0, 1'b0);
      cyc(10); send(8'hF0); cyc(9); send(8'h1C);
      head_is("make1C_still", 8'h1C, 1'b0, 1'b0);
      pop();
      head_is("break1C", 8'h1C, 1'b0, 1'b1);
      pop();
      chk("empty_after_1C", 32'(bus.ev_valid), 32'd0);
      chk("hold_code", 32'(bus.ev_code), 32'h1C);
      chk("hold_brk", 32'(bus.ev_break), 32'd1);

      // extended make/break
      send(8'hE0); send(8'h75);
      send(8'hE0); send(8'hF0); send(8'h75);
      head_is("ext_make75", 8'h75, 1'b1, 1'b0);
      pop();
      head_is("ext_brk75", 8'h75, 1'b1, 1'b1);
      pop();

      // status bytes ignored only in IDLE
      send(8'hAA); send(8'hFA); cyc(2);
      chk("status_dropped", 32'(bus.ev_valid), 32'd0);
      send(8'hF0); send(8'hFA);
      head_is("brk_FA", 8'hFA, 1'b0, 1'b1);
      pop();

      // watchdog abandons a lone E0
      send(8'hE0);
      first = 0; highs = 0;
      for (int i = 1; i <= 60; i++) begin
         cyc(1);
         if (bus.timeout_tick) begin
            highs++;
            if (first == 0) first = i;
         end
      end
      chk("timeout_cycle", 32'(first), 32'd50);
      chk("timeout_width", 32'(highs), 32'd1);
      send(8'h1C);
      head_is("after_timeout", 8'h1C, 1'b0, 1'b0);
      pop();

      // overflow with no reader
      for (int i = 0; i < 4; i++) begin send(codes[i]); cyc(1); end
      chk("full_after4", 32'(bus.fifo_full), 32'd1);
      chk("no_ovf_yet", 32'(bus.overflow), 32'd0);
      send(codes[4]);
      chk("ovf_set", 32'(bus.overflow), 32'd1);
      for (int i = 0; i < 4; i++) begin
         head_is("drain", codes[i], 1'b0, 1'b0);
         pop();
      end
      chk("drained_valid", 32'(bus.ev_valid), 32'd0);
      chk("ovf_sticky", 32'(bus.overflow), 32'd1);

      // push into full FIFO with a simultaneous pop
      do_reset();
      for (int i = 0; i < 4; i++) send(codes[i]);
      send_pop(codes[4]);
      chk("pp_ovf", 32'(bus.overflow), 32'd0);
      chk("pp_full", 32'(bus.fifo_full), 32'd1);
      head_is("pp_head", 8'h1E, 1'b0, 1'b0);
      pop(); pop(); pop();
      head_is("pp_tail", 8'h2E, 1'b0, 1'b0);
      pop();
      chk("pp_empty", 32'(bus.ev_valid), 32'd0);

      // reset mid-sequence discards the pending E0
      send(8'hE0);
      do_reset();
      send(8'h75);
      head_is("post_reset75", 8'h75, 1'b0, 1'b0);
      cyc(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "time limit");
   end
endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
Sequencer that sits directly behind the PS/2 byte receiver on the Nexys board. It consumes the receiver's byte strobe and data and decodes PS/2 set-2 prefix sequences (E0 extended, F0 break) into complete key events. Events are buffered in a small show-ahead FIFO for the application logic. A watchdog abandons half-received prefix sequences so a glitched or lost byte cannot desynchronise decoding.

Parameters:
DEPTH_LOG2, 2, log2 of event FIFO depth (4 entries).
TIMEOUT_CYC, 200000, clk_nexys cycles allowed between bytes of one sequence (2 ms at 100 MHz).
CNT_W, 18, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
clk_nexys  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high
rx_done_tick  in  1  one-cycle strobe from receiver: dato valid this cycle
dato  in  8  received byte, sampled only when rx_done_tick=1
rd_en  in  1  pop head event; ignored when ev_valid=0
ev_valid  out  1  FIFO not empty
ev_code  out  8  head event scan code (final non-prefix byte)
ev_ext  out  1  head event had E0 prefix
ev_break  out  1  head event had F0 prefix (key release)
fifo_full  out  1  FIFO holds 2^DEPTH_LOG2 entries
overflow  out  1  sticky: an event was dropped because FIFO full
timeout_tick  out  1  one-cycle pulse when watchdog aborts a sequence

Behaviour:
- Reset (async): state=IDLE, watchdog=0, FIFO pointers/count=0; ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, fifo_full=0, overflow=0, timeout_tick=0. Reset mid-sequence discards partial prefix and all buffered events.
- Decoder FSM, advances only on rx_done_tick=1:
  - IDLE: E0 -> GOT_E0; F0 -> GOT_F0; 0xAA, 0xFA, 0xFC, 0xEE, 0x00, 0xFF -> discarded, stay IDLE; other -> push {ext=0,brk=0,code}, stay IDLE.
  - GOT_E0: F0 -> GOT_E0F0; E0 -> stay; other -> push {1,0,code}, IDLE.
  - GOT_F0: E0 -> GOT_E0F0; F0 -> stay; other -> push {0,1,code}, IDLE.
  - GOT_E0F0: E0/F0 -> stay; other -> push {1,1,code}, IDLE.
  - Status-byte discard applies only in IDLE; in prefix states those bytes are treated as codes.
- Watchdog: cleared on every rx_done_tick and whenever state=IDLE; otherwise increments each cycle. When it reaches TIMEOUT_CYC-1 with no rx_done_tick that cycle: next state IDLE, timeout_tick=1 for exactly one cycle, nothing pushed. rx_done_tick in the same cycle wins (byte processed, no timeout).
- FIFO: 2^DEPTH_LOG2 entries of 10 bits {ext,brk,code}, show-ahead. ev_code/ev_ext/ev_break always reflect the head entry while ev_valid=1; hold last popped values when empty.
- Latency: rx_done_tick carrying a final code in cycle N -> entry written at end of N; ev_valid=1 in N+1 if previously empty.
- Pop: rd_en=1 and ev_valid=1 removes the head at end of cycle; the next entry is visible the following cycle.
- Push while full: if rd_en=1 and ev_valid=1 that same cycle, both push and pop occur, count unchanged, no drop. Otherwise the event is dropped, overflow set to 1, held until reset.
- Push and pop while not full/empty: count unchanged, both pointers advance, wrap modulo 2^DEPTH_LOG2.
- Push into empty with rd_en=1 the same cycle: rd_en ignored (ev_valid still 0); entry retained.
- fifo_full and ev_valid are registered functions of count; no combinational path from rx_done_tick to outputs.

Test Plan:
- Byte 0x1C then 0xF0,0x1C (ticks 10 cycles apart) -> two events: {code=1C,ext=0,brk=0}, then {1C,0,1}; ev_valid rises the cycle after each final tick.
- 0xE0,0x75 then 0xE0,0xF0,0x75 -> events {75,1,0} and {75,1,1}; order preserved across pops.
- 0xAA and 0xFA in IDLE -> no events, ev_valid stays 0; 0xF0,0xFA -> event {FA,0,1}.
- 0xE0 then silence for TIMEOUT_CYC cycles (use TIMEOUT_CYC=50 in sim) -> timeout_tick single pulse at cycle 50, state IDLE; then 0x1C -> event {1C,0,0} (not extended).
- 5 make codes 0x16,0x1E,0x26,0x25,0x2E with rd_en=0 -> fifo_full=1 after 4th, 5th dropped, overflow=1; pop 4 -> 16,1E,26,25, then ev_valid=0, overflow still 1.
- FIFO full, 5th code tick with rd_en=1 same cycle -> no drop, overflow=0, head advances to 0x1E, tail holds 0x2E; assert reset mid-sequence after 0xE0 -> all outputs 0, next 0x75 yields {75,0,0}.
